// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_ctrl
// Description : SPI master for the single-clock SPI slave + RAM wrapper.
//               Serialises one {cmd, tx_byte} command per frame, MSB first,
//               one bit per clk, and for read-data frames (cmd=11) captures
//               the 8 bits returned on MISO into rd_data.
//               Optional macro SPI_MASTER_CMD_BUF_EN adds a one-entry command
//               buffer and the buf_full output.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
  parameter int RD_WAIT  = 1,   // turnaround cycles before first MISO sample, 1..7
  parameter int IDLE_GAP = 2    // SS_n high cycles between frames, 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
`ifdef SPI_MASTER_CMD_BUF_EN
  ,
  output logic       buf_full
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_CMD   = 3'd2,
    S_SHIFT = 3'd3,
    S_WAIT  = 3'd4,
    S_RECV  = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  localparam logic [3:0] C_SHIFT_LEN = 4'd10;
  localparam logic [3:0] C_RECV_LEN  = 4'd8;
  localparam logic [3:0] C_WAIT_LEN  = 4'(RD_WAIT);
  localparam logic [3:0] C_GAP_LEN   = 4'(IDLE_GAP);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] frame_q, frame_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       done_q, done_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic [3:0] w_bit_idx;
  logic [9:0] w_frame_in;

`ifdef SPI_MASTER_CMD_BUF_EN
  logic       buf_full_q, buf_full_d;
  logic [9:0] buf_frame_q, buf_frame_d;
`endif

  // Frame as seen on the wire; the read-data opcode carries a zero payload.
  assign w_frame_in = {cmd, (cmd == 2'b11) ? 8'h00 : tx_byte};

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    shadow_d   = shadow_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    ss_n_d     = ss_n_q;
    mosi_d     = 1'b0;
    busy_d     = busy_q;
    w_bit_idx  = 4'd9 - cnt_q;
`ifdef SPI_MASTER_CMD_BUF_EN
    buf_full_d  = buf_full_q;
    buf_frame_d = buf_frame_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef SPI_MASTER_CMD_BUF_EN
        if (buf_full_q) begin
          frame_d    = buf_frame_q;
          buf_full_d = 1'b0;
          state_d    = S_START;
          ss_n_d     = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = 4'd0;
        end else
`endif
        if (start) begin
          frame_d = w_frame_in;
          state_d = S_START;
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      S_START: begin
        // CMD cycle repeats the opcode MSB so the slave can pick its path.
        state_d = S_CMD;
        mosi_d  = frame_q[9];
      end
      S_CMD: begin
        state_d = S_SHIFT;
        mosi_d  = frame_q[9];
        cnt_d   = 4'd1;
      end
      S_SHIFT: begin
        // cnt_q = number of frame bits already presented on MOSI.
        if (cnt_q == C_SHIFT_LEN) begin
          cnt_d = 4'd1;
          if (frame_q[9:8] == 2'b11) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_GAP;
            ss_n_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          mosi_d = frame_q[w_bit_idx];
          cnt_d  = cnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == C_WAIT_LEN) begin
          state_d = S_RECV;
          cnt_d   = 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RECV: begin
        // MISO is sampled at the end of each RECV cycle, first bit lands in bit 7.
        shadow_d = {shadow_q[6:0], MISO};
        if (cnt_q == C_RECV_LEN) begin
          state_d    = S_GAP;
          ss_n_d     = 1'b1;
          done_d     = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = {shadow_q[6:0], MISO};
          cnt_d      = 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == C_GAP_LEN) begin
`ifdef SPI_MASTER_CMD_BUF_EN
          if (buf_full_q) begin
            frame_d    = buf_frame_q;
            buf_full_d = 1'b0;
            state_d    = S_START;
            ss_n_d     = 1'b0;
            cnt_d      = 4'd0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
          end
`else
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ss_n_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
`ifdef SPI_MASTER_CMD_BUF_EN
    // A start while busy parks in the buffer; launch and capture never overlap
    // because launch needs a full buffer and capture needs an empty one.
    if (start && busy_q && !buf_full_q) begin
      buf_full_d  = 1'b1;
      buf_frame_d = w_frame_in;
    end
`endif
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      frame_q    <= 10'd0;
      shadow_q   <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SPI_MASTER_CMD_BUF_EN
      buf_full_q  <= 1'b0;
      buf_frame_q <= 10'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      shadow_q   <= shadow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
`ifdef SPI_MASTER_CMD_BUF_EN
      buf_full_q  <= buf_full_d;
      buf_frame_q <= buf_frame_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;
`ifdef SPI_MASTER_CMD_BUF_EN
  assign buf_full = buf_full_q;
`endif

endmodule
`default_nettype wire
